jr_pc_redirect_unit: RTL and testbench

//  Consumer side of the JR decode: owns the PC register and applies JR / jump / branch

---
 rtl/jr_pc_redirect_unit_if.sv | 26 ++
 rtl/jr_pc_redirect_unit.sv | 143 ++++++++++++++
 tb/tb_jr_pc_redirect_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/jr_pc_redirect_unit_if.sv
// Fetch-side bus between decode/control and the PC redirect unit.
// master drives redirect requests and stall; slave owns the PC and reports it.
interface jr_pc_redirect_unit_if;
  logic        stall;
  logic        jr_control;
  logic [31:0] jr_target;
  logic        jump;
  logic [25:0] jump_index;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        flush;
  logic [15:0] redirect_count;
  logic        misalign_trap;

  modport master (
    output stall, jr_control, jr_target, jump, jump_index, branch_taken, branch_offset,
    input  pc, fetch_valid, flush, redirect_count, misalign_trap
  );

  modport slave (
    input  stall, jr_control, jr_target, jump, jump_index, branch_taken, branch_offset,
    output pc, fetch_valid, flush, redirect_count, misalign_trap
  );
endinterface

// File: rtl/jr_pc_redirect_unit.sv
// PC owner: applies JR/jump/branch redirects and inserts fetch bubbles afterwards.
// Optional misaligned-JR trapping is enabled by defining PC_ALIGN_CHECK_EN.
module jr_pc_redirect_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1
`ifdef PC_ALIGN_CHECK_EN
  ,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080
`endif
) (
  input logic clk,
  input logic reset,
  jr_pc_redirect_unit_if.slave bus
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_t      state_r;
  logic [31:0] pc_r;
  logic [3:0]  bubble_r;
  logic [15:0] count_r;
  logic        flush_r;

  logic [31:0] pc4_s;
  logic [31:0] jtgt_s;
  logic [31:0] btgt_s;
  logic [31:0] target_s;
  logic        redirect_s;
  logic        accept_s;
  logic        trap_s;

`ifdef PC_ALIGN_CHECK_EN
  logic        trap_r;
`endif

  // Next-PC candidates and redirect selection (jr > jump > branch).
  always_comb begin
    pc4_s      = pc_r + 32'd4;
    jtgt_s     = {pc4_s[31:28], bus.jump_index, 2'b00};
    btgt_s     = pc4_s + {{14{bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
    redirect_s = bus.jr_control | bus.jump | bus.branch_taken;
    trap_s     = 1'b0;
    if (bus.jr_control) begin
`ifdef PC_ALIGN_CHECK_EN
      if (bus.jr_target[1:0] != 2'b00) begin
        target_s = TRAP_VECTOR;
        trap_s   = 1'b1;
      end else begin
        target_s = bus.jr_target;
      end
`else
      target_s = bus.jr_target & 32'hFFFF_FFFC;
`endif
    end else if (bus.jump) begin
      target_s = jtgt_s;
    end else if (bus.branch_taken) begin
      target_s = btgt_s;
    end else begin
      target_s = pc4_s;
    end
    accept_s = (state_r == RUN) && !bus.stall && redirect_s;
  end

  // PC, bubble counter, redirect counter and flush pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= RUN;
      pc_r     <= RESET_PC;
      bubble_r <= 4'd0;
      count_r  <= 16'd0;
      flush_r  <= 1'b0;
    end else begin
      flush_r <= accept_s;
      case (state_r)
        RUN: begin
          if (!bus.stall) begin
            pc_r <= target_s;
            if (redirect_s) begin
              if (count_r != 16'hFFFF) begin
                count_r <= count_r + 16'd1;
              end else begin
                count_r <= count_r;
              end
              if (FLUSH_INIT != 4'd0) begin
                state_r  <= FLUSH;
                bubble_r <= FLUSH_INIT;
              end else begin
                state_r  <= RUN;
              end
            end else begin
              state_r <= RUN;
            end
          end else begin
            state_r <= RUN;
          end
        end
        FLUSH: begin
          // Wrong-path redirects are ignored; only an unstalled cycle burns a bubble.
          if (!bus.stall) begin
            if (bubble_r <= 4'd1) begin
              bubble_r <= 4'd0;
              state_r  <= RUN;
            end else begin
              bubble_r <= bubble_r - 4'd1;
            end
          end else begin
            bubble_r <= bubble_r;
          end
        end
        default: begin
          state_r  <= RUN;
          bubble_r <= 4'd0;
        end
      endcase
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // Misaligned-JR pulse, aligned with flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trap_r <= 1'b0;
    end else begin
      trap_r <= accept_s && trap_s;
    end
  end

  assign bus.misalign_trap = trap_r;
`else
  assign bus.misalign_trap = 1'b0;
`endif

  assign bus.pc             = pc_r;
  assign bus.fetch_valid    = (state_r == RUN);
  assign bus.flush          = flush_r;
  assign bus.redirect_count = count_r;

endmodule

// File: tb/tb_jr_pc_redirect_unit.sv
// Directed table-driven bench for jr_pc_redirect_unit (default parameters).
module tb_jr_pc_redirect_unit;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  jr_pc_redirect_unit_if bus ();

  jr_pc_redirect_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        jr;
    logic [31:0] jt;
    logic        jmp;
    logic [25:0] ji;
    logic        br;
    logic [15:0] bo;
    logic [31:0] e_pc;
    logic        e_fv;
    logic        e_fl;
    logic [15:0] e_cnt;
    logic        e_trap;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic jr, input logic [31:0] jt,
                       input logic jmp, input logic [25:0] ji,
                       input logic br, input logic [15:0] bo);
    bus.stall         = s;
    bus.jr_control    = jr;
    bus.jr_target     = jt;
    bus.jump          = jmp;
    bus.jump_index    = ji;
    bus.branch_taken  = br;
    bus.branch_offset = bo;
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic e_fv,
                           input logic e_fl, input logic [15:0] e_cnt, input logic e_trap);
    chk({tag, ".pc"}, bus.pc, e_pc);
    chk({tag, ".fetch_valid"}, {31'd0, bus.fetch_valid}, {31'd0, e_fv});
    chk({tag, ".flush"}, {31'd0, bus.flush}, {31'd0, e_fl});
    chk({tag, ".redirect_count"}, {16'd0, bus.redirect_count}, {16'd0, e_cnt});
    chk({tag, ".misalign_trap"}, {31'd0, bus.misalign_trap}, {31'd0, e_trap});
  endtask

  task automatic add(input logic s, input logic jr, input logic [31:0] jt,
                     input logic jmp, input logic [25:0] ji, input logic br,
                     input logic [15:0] bo, input logic [31:0] e_pc, input logic e_fv,
                     input logic e_fl, input logic [15:0] e_cnt, input logic e_trap);
    vec_t v;
    v.stall = s; v.jr = jr; v.jt = jt; v.jmp = jmp; v.ji = ji; v.br = br; v.bo = bo;
    v.e_pc = e_pc; v.e_fv = e_fv; v.e_fl = e_fl; v.e_cnt = e_cnt; v.e_trap = e_trap;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] mis_pc;
    logic        mis_trap;
    total = 0;
    bad   = 0;
`ifdef PC_ALIGN_CHECK_EN
    mis_pc   = 32'h0000_0080;
    mis_trap = 1'b1;
`else
    mis_pc   = 32'h0000_2000;
    mis_trap = 1'b0;
`endif
    // stall jr jt jmp ji br bo | pc fv flush count trap
    add(1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       1'b0, 16'h0,    32'h0000_0004, 1'b1, 1'b0, 16'd0,  1'b0);
    add(1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       1'b0, 16'h0,    32'h0000_0008, 1'b1, 1'b0, 16'd0,  1'b0);
    add(1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       1'b0, 16'h0,    32'h0000_000C, 1'b1, 1'b0, 16'd0,  1'b0);
    add(1'b0, 1'b1, 32'h0000_0100, 1'b0, 26'h0,       1'b0, 16'h0,    32'h0000_0100, 1'b0, 1'b1, 16'd1,  1'b0);
    add(1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       1'b0, 16'h0,    32'h0000_0100, 1'b1, 1'b0, 16'd1,  1'b0);
    add(1'b0, 1'b1, 32'h0000_2000, 1'b1, 26'h5,       1'b0, 16'h0,    32'h0000_2000, 1'b0, 1'b1, 16'd2,  1'b0);
    add(1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       1'b0, 16'h0,    32'h0000_2000, 1'b1, 1'b0, 16'd2,  1'b0);
    add(1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       1'b0, 16'h0,    32'h0000_2004, 1'b1, 1'b0, 16'd2,  1'b0);
    add(1'b0, 1'b1, 32'h1000_0040, 1'b0, 26'h0,       1'b0, 16'h0,    32'h1000_0040, 1'b0, 1'b1, 16'd3,  1'b0);
    add(1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       1'b1, 16'h0003, 32'h1000_0040, 1'b1, 1'b0, 16'd3,  1'b0);
    add(1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       1'b1, 16'hFFFE, 32'h1000_003C, 1'b0, 1'b1, 16'd4,  1'b0);
    add(1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       1'b0, 16'h0,    32'h1000_003C, 1'b1, 1'b0, 16'd4,  1'b0);
    add(1'b0, 1'b1, 32'h1000_0040, 1'b0, 26'h0,       1'b0, 16'h0,    32'h1000_0040, 1'b0, 1'b1, 16'd5,  1'b0);
    add(1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       1'b0, 16'h0,    32'h1000_0040, 1'b1, 1'b0, 16'd5,  1'b0);
    add(1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       1'b1, 16'h0003, 32'h1000_0050, 1'b0, 1'b1, 16'd6,  1'b0);
    add(1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       1'b0, 16'h0,    32'h1000_0050, 1'b1, 1'b0, 16'd6,  1'b0);
    add(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0,       1'b0, 16'h0,    32'hFFFF_FFFC, 1'b0, 1'b1, 16'd7,  1'b0);
    add(1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       1'b0, 16'h0,    32'hFFFF_FFFC, 1'b1, 1'b0, 16'd7,  1'b0);
    add(1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       1'b0, 16'h0,    32'h0000_0000, 1'b1, 1'b0, 16'd7,  1'b0);
    add(1'b0, 1'b1, 32'h4000_0000, 1'b0, 26'h0,       1'b0, 16'h0,    32'h4000_0000, 1'b0, 1'b1, 16'd8,  1'b0);
    add(1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       1'b0, 16'h0,    32'h4000_0000, 1'b1, 1'b0, 16'd8,  1'b0);
    add(1'b0, 1'b0, 32'h0,         1'b1, 26'h3FF_FFFF, 1'b0, 16'h0,   32'h4FFF_FFFC, 1'b0, 1'b1, 16'd9,  1'b0);
    add(1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       1'b0, 16'h0,    32'h4FFF_FFFC, 1'b1, 1'b0, 16'd9,  1'b0);
    add(1'b1, 1'b0, 32'h0,         1'b0, 26'h0,       1'b1, 16'h0010, 32'h4FFF_FFFC, 1'b1, 1'b0, 16'd9,  1'b0);
    add(1'b1, 1'b1, 32'h0000_3000, 1'b0, 26'h0,       1'b0, 16'h0,    32'h4FFF_FFFC, 1'b1, 1'b0, 16'd9,  1'b0);
    add(1'b0, 1'b1, 32'h0000_2002, 1'b0, 26'h0,       1'b0, 16'h0,    mis_pc,        1'b0, 1'b1, 16'd10, mis_trap);
    add(1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       1'b0, 16'h0,    mis_pc,        1'b1, 1'b0, 16'd10, 1'b0);
    add(1'b0, 1'b0, 32'h0,         1'b1, 26'h40,      1'b1, 16'h0100, 32'h0000_0100, 1'b0, 1'b1, 16'd11, 1'b0);
    add(1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       1'b0, 16'h0,    32'h0000_0100, 1'b1, 1'b0, 16'd11, 1'b0);

    // Reset state
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 32'h0, 1'b1, 1'b0, 16'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stall, vecs[i].jr, vecs[i].jt, vecs[i].jmp, vecs[i].ji, vecs[i].br, vecs[i].bo);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_fv, vecs[i].e_fl,
                vecs[i].e_cnt, vecs[i].e_trap);
    end

    // Redirect then stall three cycles in FLUSH with a wrong-path branch pending
    drive(1'b0, 1'b1, 32'h0000_3000, 1'b0, 26'h0, 1'b0, 16'h0);
    @(posedge clk); #1;
    check_all("stallflush.accept", 32'h0000_3000, 1'b0, 1'b1, 16'd12, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 16'h0020);
      @(posedge clk); #1;
      check_all($sformatf("stallflush.hold%0d", k), 32'h0000_3000, 1'b0, 1'b0, 16'd12, 1'b0);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 16'h0020);
    @(posedge clk); #1;
    check_all("stallflush.release", 32'h0000_3000, 1'b1, 1'b0, 16'd12, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 16'h0);
    @(posedge clk); #1;
    check_all("stallflush.seq", 32'h0000_3004, 1'b1, 1'b0, 16'd12, 1'b0);

    // Reset asserted mid-FLUSH takes effect without a clock edge
    drive(1'b0, 1'b1, 32'h0000_4000, 1'b0, 26'h0, 1'b0, 16'h0);
    @(posedge clk); #1;
    check_all("midreset.accept", 32'h0000_4000, 1'b0, 1'b1, 16'd13, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 16'h0);
    #2;
    reset = 1'b1;
    #1;
    check_all("midreset.async", 32'h0, 1'b1, 1'b0, 16'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_all("midreset.after", 32'h0000_0004, 1'b1, 1'b0, 16'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
